// File: rtl/mul_arbiter_if.sv
// mul_arbiter_if: request/response bundle between requesters and mul_arbiter.
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high; a producer holds valid and its payload until that edge, and
// ready may depend combinationally on valid.
// Requester i uses req_valid[i], req_ready[i], req_a/req_b[i*LEN +: LEN].
interface mul_arbiter_if #(
  parameter int LEN  = 16,
  parameter int NREQ = 4,
  parameter int FULL = 0,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1,
  parameter int OW   = (FULL != 0) ? 2 * LEN : LEN
);
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*LEN-1:0] req_a;
  logic [NREQ*LEN-1:0] req_b;
  logic                resp_valid;
  logic                resp_ready;
  logic [IW-1:0]       resp_id;
  logic [OW-1:0]       resp_y;

  // Arbiter side
  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_y
  );

  // Requester / consumer side
  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_y
  );
endinterface

// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin sharing of one LEN x LEN multiplier between NREQ
// requesters. Two pipeline stages: S1 holds the granted operands and owner
// ID, S2 holds the product and ID and drives the response bus.
// Optional build macro MUL_ARBITER_PERF_EN adds saturating 16-bit counters
// perf_stall (cycles with resp_valid & !resp_ready) and perf_grants (accepts).
module mul_arbiter #(
  parameter int LEN    = 16,
  parameter int NREQ   = 4,
  parameter int FULL   = 0,
  parameter int SIGNED = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  mul_arbiter_if.slave   bus,
  output logic           busy
`ifdef MUL_ARBITER_PERF_EN
  ,
  output logic [15:0]    perf_stall,
  output logic [15:0]    perf_grants
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int OW = (FULL != 0) ? 2 * LEN : LEN;

  typedef logic [IW-1:0] id_t;

  // Circular search position: base + k wrapped into 0..NREQ-1.
  function automatic id_t wrap_idx(input id_t base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return id_t'(s);
  endfunction

  // Pipeline state
  logic           s1_v_q, s1_v_d;
  logic [LEN-1:0] s1_a_q, s1_a_d;
  logic [LEN-1:0] s1_b_q, s1_b_d;
  id_t            s1_id_q, s1_id_d;
  logic           s2_v_q, s2_v_d;
  logic [OW-1:0]  s2_y_q, s2_y_d;
  id_t            s2_id_q, s2_id_d;
  id_t            rr_q, rr_d;

  // Stall/advance and arbitration signals
  logic            s2_free;
  logic            s1_adv;
  logic            s1_free;
  logic            grant_found;
  id_t             grant_id;
  logic [LEN-1:0]  grant_a;
  logic [LEN-1:0]  grant_b;
  logic            accept;
  logic [NREQ-1:0] ready_onehot;
  logic [OW-1:0]   prod;

  // Pipeline flow control and circular first-valid search from rr_q
  always_comb begin
    s2_free      = !s2_v_q || bus.resp_ready;
    s1_adv       = s1_v_q && s2_free;
    s1_free      = !s1_v_q || s1_adv;
    grant_found  = 1'b0;
    grant_id     = '0;
    grant_a      = '0;
    grant_b      = '0;
    ready_onehot = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_found && bus.req_valid[wrap_idx(rr_q, k)]) begin
        grant_found = 1'b1;
        grant_id    = wrap_idx(rr_q, k);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (grant_found && (id_t'(i) == grant_id)) begin
        grant_a = bus.req_a[i*LEN +: LEN];
        grant_b = bus.req_b[i*LEN +: LEN];
      end
    end
    accept = s1_free && grant_found;
    if (accept) ready_onehot[grant_id] = 1'b1;
  end

  // Nothing is accepted while reset is held, even though the stages look free
  assign bus.req_ready = rst_n ? ready_onehot : '0;

  // Product width/sign handling; low half is sign-agnostic so only FULL cares
  if (FULL != 0) begin : g_full
    logic [OW-1:0] ax;
    logic [OW-1:0] bx;
    assign ax   = (SIGNED != 0) ? {{LEN{s1_a_q[LEN-1]}}, s1_a_q} : {{LEN{1'b0}}, s1_a_q};
    assign bx   = (SIGNED != 0) ? {{LEN{s1_b_q[LEN-1]}}, s1_b_q} : {{LEN{1'b0}}, s1_b_q};
    assign prod = ax * bx;
  end else begin : g_trunc
    assign prod = s1_a_q * s1_b_q;
  end

  // Next state for S1, S2 and the round-robin pointer
  always_comb begin
    s1_v_d  = s1_v_q;
    s1_a_d  = s1_a_q;
    s1_b_d  = s1_b_q;
    s1_id_d = s1_id_q;
    s2_v_d  = s2_v_q;
    s2_y_d  = s2_y_q;
    s2_id_d = s2_id_q;
    rr_d    = rr_q;
    // S2 takes the product whenever S1 moves on; otherwise a drain empties it
    if (s1_adv) begin
      s2_v_d  = 1'b1;
      s2_y_d  = prod;
      s2_id_d = s1_id_q;
    end else if (bus.resp_ready) begin
      s2_v_d = 1'b0;
    end
    // S1 refills on an accept; otherwise it empties when its content advances
    if (accept) begin
      s1_v_d  = 1'b1;
      s1_a_d  = grant_a;
      s1_b_d  = grant_b;
      s1_id_d = grant_id;
      rr_d    = (grant_id == id_t'(NREQ - 1)) ? '0 : grant_id + id_t'(1);
    end else if (s1_adv) begin
      s1_v_d = 1'b0;
    end
  end

  // Pipeline registers; reset discards anything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q  <= 1'b0;
      s1_a_q  <= '0;
      s1_b_q  <= '0;
      s1_id_q <= '0;
      s2_v_q  <= 1'b0;
      s2_y_q  <= '0;
      s2_id_q <= '0;
      rr_q    <= '0;
    end else begin
      s1_v_q  <= s1_v_d;
      s1_a_q  <= s1_a_d;
      s1_b_q  <= s1_b_d;
      s1_id_q <= s1_id_d;
      s2_v_q  <= s2_v_d;
      s2_y_q  <= s2_y_d;
      s2_id_q <= s2_id_d;
      rr_q    <= rr_d;
    end
  end

  assign bus.resp_valid = s2_v_q;
  assign bus.resp_id    = s2_id_q;
  assign bus.resp_y     = s2_y_q;
  assign busy           = s1_v_q | s2_v_q;

`ifdef MUL_ARBITER_PERF_EN
  logic [15:0] stall_q, stall_d;
  logic [15:0] grants_q, grants_d;

  // Saturating event counters
  always_comb begin
    stall_d  = stall_q;
    grants_d = grants_q;
    if (s2_v_q && !bus.resp_ready && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
    if (accept && (grants_q != 16'hFFFF)) grants_d = grants_q + 16'd1;
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q  <= '0;
      grants_q <= '0;
    end else begin
      stall_q  <= stall_d;
      grants_q <= grants_d;
    end
  end

  assign perf_stall  = stall_q;
  assign perf_grants = grants_q;
`endif

endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: directed checks of mul_arbiter. Main instance LEN=16,
// NREQ=4, FULL=0; two side instances (FULL=1, SIGNED=1/0, NREQ=2) cover the
// wide product. Perf counters are checked when MUL_ARBITER_PERF_EN is set.
module tb_mul_arbiter;

  logic clk;
  logic rst_n;
  logic busy0, busy_fs, busy_fu;
  int   tests_run;
  int   tests_failed;
  logic [17:0] exp_q[$];

  mul_arbiter_if #(.LEN(16), .NREQ(4), .FULL(0)) bus0 ();
  mul_arbiter_if #(.LEN(16), .NREQ(2), .FULL(1)) bus_fs ();
  mul_arbiter_if #(.LEN(16), .NREQ(2), .FULL(1)) bus_fu ();

`ifdef MUL_ARBITER_PERF_EN
  logic [15:0] stall0, grants0, stall_fs, grants_fs, stall_fu, grants_fu;
`endif

  mul_arbiter #(.LEN(16), .NREQ(4), .FULL(0), .SIGNED(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .busy(busy0)
`ifdef MUL_ARBITER_PERF_EN
    , .perf_stall(stall0), .perf_grants(grants0)
`endif
  );

  mul_arbiter #(.LEN(16), .NREQ(2), .FULL(1), .SIGNED(1)) u_fs (
    .clk(clk), .rst_n(rst_n), .bus(bus_fs), .busy(busy_fs)
`ifdef MUL_ARBITER_PERF_EN
    , .perf_stall(stall_fs), .perf_grants(grants_fs)
`endif
  );

  mul_arbiter #(.LEN(16), .NREQ(2), .FULL(1), .SIGNED(0)) u_fu (
    .clk(clk), .rst_n(rst_n), .bus(bus_fu), .busy(busy_fu)
`ifdef MUL_ARBITER_PERF_EN
    , .perf_stall(stall_fu), .perf_grants(grants_fu)
`endif
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Driver helper: load operands of one requester on the main bus
  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    bus0.req_a[i*16 +: 16] = a;
    bus0.req_b[i*16 +: 16] = b;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if ({bus0.resp_valid, bus0.resp_id, bus0.resp_y, busy0} !== 20'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got v=%b id=%0d y=%h busy=%b, exp all zero",
               bus0.resp_valid, bus0.resp_id, bus0.resp_y, busy0);
    end
    tests_run++;
    if (bus0.req_ready !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_req_ready: got %b exp 0000", bus0.req_ready);
    end
    bus0.req_valid = '0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_latency();
    set_op(2, 16'h0003, 16'h0005);
    bus0.req_valid  = 4'b0100;
    bus0.resp_ready = 1'b1;
    #1;
    tests_run++;
    if (bus0.req_ready !== 4'b0100) begin
      tests_failed++;
      $display("FAIL lat_grant: got %b exp 0100", bus0.req_ready);
    end
    @(negedge clk);
    bus0.req_valid = '0;
    #1;
    tests_run++;
    if ({bus0.resp_valid, busy0} !== 2'b01) begin
      tests_failed++;
      $display("FAIL lat_s1: got valid=%b busy=%b exp valid=0 busy=1", bus0.resp_valid, busy0);
    end
    @(negedge clk);
    tests_run++;
    if ({bus0.resp_valid, bus0.resp_id, bus0.resp_y, busy0} !== {1'b1, 2'd2, 16'h000F, 1'b1}) begin
      tests_failed++;
      $display("FAIL lat_resp: got v=%b id=%0d y=%h busy=%b exp v=1 id=2 y=000f busy=1",
               bus0.resp_valid, bus0.resp_id, bus0.resp_y, busy0);
    end
    @(negedge clk);
    tests_run++;
    if ({bus0.resp_valid, busy0} !== 2'b00) begin
      tests_failed++;
      $display("FAIL lat_drain: got valid=%b busy=%b exp 0 0", bus0.resp_valid, busy0);
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] exp_y [4];
    logic [3:0]  exp_rdy;
    logic [1:0]  exp_id;
    exp_y[0] = 16'h0006;
    exp_y[1] = 16'h0000;
    exp_y[2] = 16'h2468;
    exp_y[3] = 16'h0001;
    do_reset();
    set_op(0, 16'h0002, 16'h0003);
    set_op(1, 16'h0100, 16'h0100);
    set_op(2, 16'h1234, 16'h0002);
    set_op(3, 16'hFFFF, 16'hFFFF);
    bus0.req_valid  = 4'hF;
    bus0.resp_ready = 1'b1;
    for (int k = 0; k < 11; k++) begin
      if (k == 9) bus0.req_valid = '0;
      #1;
      exp_rdy = (k < 9) ? 4'(1 << (k % 4)) : 4'b0000;
      tests_run++;
      if (bus0.req_ready !== exp_rdy) begin
        tests_failed++;
        $display("FAIL rr_grant[%0d]: got %b exp %b", k, bus0.req_ready, exp_rdy);
      end
      if (k >= 2) begin
        exp_id = 2'((k - 2) % 4);
        tests_run++;
        if ({bus0.resp_valid, bus0.resp_id, bus0.resp_y} !== {1'b1, exp_id, exp_y[exp_id]}) begin
          tests_failed++;
          $display("FAIL rr_resp[%0d]: got v=%b id=%0d y=%h exp v=1 id=%0d y=%h",
                   k, bus0.resp_valid, bus0.resp_id, bus0.resp_y, exp_id, exp_y[exp_id]);
        end
      end
      @(negedge clk);
    end
    tests_run++;
    if ({bus0.resp_valid, busy0} !== 2'b00) begin
      tests_failed++;
      $display("FAIL rr_idle: got valid=%b busy=%b exp 0 0", bus0.resp_valid, busy0);
    end
  endtask

  task automatic test_single();
    set_op(3, 16'h0011, 16'h0003);
    bus0.req_valid = 4'b1000;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) bus0.req_valid = '0;
      #1;
      tests_run++;
      if (bus0.req_ready !== ((k < 4) ? 4'b1000 : 4'b0000)) begin
        tests_failed++;
        $display("FAIL single_grant[%0d]: got %b exp %b", k, bus0.req_ready,
                 (k < 4) ? 4'b1000 : 4'b0000);
      end
      if (k >= 2) begin
        tests_run++;
        if ({bus0.resp_valid, bus0.resp_id, bus0.resp_y} !== {1'b1, 2'd3, 16'h0033}) begin
          tests_failed++;
          $display("FAIL single_resp[%0d]: got v=%b id=%0d y=%h exp v=1 id=3 y=0033",
                   k, bus0.resp_valid, bus0.resp_id, bus0.resp_y);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back_backpressure();
    logic [17:0] exp;
    int got;
    got = 0;
    set_op(0, 16'h0007, 16'h0009);
    set_op(1, 16'h0010, 16'h0010);
    bus0.resp_ready = 1'b0;
    bus0.req_valid  = 4'b0011;
    #1;
    tests_run++;
    if (bus0.req_ready !== 4'b0001) begin
      tests_failed++;
      $display("FAIL bp_grant0: got %b exp 0001", bus0.req_ready);
    end
    exp_q.push_back({2'd0, 16'h003F});
    @(negedge clk);
    bus0.req_valid = 4'b0010;
    #1;
    tests_run++;
    if (bus0.req_ready !== 4'b0010) begin
      tests_failed++;
      $display("FAIL bp_grant1: got %b exp 0010", bus0.req_ready);
    end
    exp_q.push_back({2'd1, 16'h0100});
    @(negedge clk);
    bus0.req_valid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests_run++;
      if ({bus0.req_ready, bus0.resp_valid, bus0.resp_id, bus0.resp_y, busy0} !==
          {4'b0000, 1'b1, 2'd0, 16'h003F, 1'b1}) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d]: got rdy=%b v=%b id=%0d y=%h busy=%b exp rdy=0000 v=1 id=0 y=003f busy=1",
                 k, bus0.req_ready, bus0.resp_valid, bus0.resp_id, bus0.resp_y, busy0);
      end
      @(negedge clk);
    end
    bus0.req_valid  = '0;
    bus0.resp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (bus0.resp_valid) begin
        got++;
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL bp_extra: got id=%0d y=%h exp no response", bus0.resp_id, bus0.resp_y);
        end else begin
          exp = exp_q.pop_front();
          if ({bus0.resp_id, bus0.resp_y} !== exp) begin
            tests_failed++;
            $display("FAIL bp_order: got id=%0d y=%h exp id=%0d y=%h",
                     bus0.resp_id, bus0.resp_y, exp[17:16], exp[15:0]);
          end
        end
      end
      @(negedge clk);
    end
    tests_run++;
    if (got !== 2 || busy0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_count: got %0d responses busy=%b exp 2 busy=0", got, busy0);
    end
    exp_q.delete();
  endtask

  task automatic test_full_signed();
    logic [15:0] va [2];
    logic [15:0] vb [2];
    logic [31:0] ys [2];
    logic [31:0] yu [2];
    va[0] = 16'hFFFF; vb[0] = 16'h0002; ys[0] = 32'hFFFFFFFE; yu[0] = 32'h0001FFFE;
    va[1] = 16'h8000; vb[1] = 16'h0003; ys[1] = 32'hFFFE8000; yu[1] = 32'h00018000;
    bus_fs.resp_ready = 1'b1;
    bus_fu.resp_ready = 1'b1;
    for (int v = 0; v < 2; v++) begin
      bus_fs.req_a = {16'h0, va[v]};
      bus_fs.req_b = {16'h0, vb[v]};
      bus_fu.req_a = {16'h0, va[v]};
      bus_fu.req_b = {16'h0, vb[v]};
      bus_fs.req_valid = 2'b01;
      bus_fu.req_valid = 2'b01;
      @(negedge clk);
      bus_fs.req_valid = 2'b00;
      bus_fu.req_valid = 2'b00;
      @(negedge clk);
      tests_run++;
      if ({bus_fs.resp_valid, bus_fs.resp_id, bus_fs.resp_y} !== {1'b1, 1'b0, ys[v]}) begin
        tests_failed++;
        $display("FAIL full_signed[%0d]: got v=%b id=%0d y=%h exp v=1 id=0 y=%h",
                 v, bus_fs.resp_valid, bus_fs.resp_id, bus_fs.resp_y, ys[v]);
      end
      tests_run++;
      if ({bus_fu.resp_valid, bus_fu.resp_y} !== {1'b1, yu[v]}) begin
        tests_failed++;
        $display("FAIL full_unsigned[%0d]: got v=%b y=%h exp v=1 y=%h",
                 v, bus_fu.resp_valid, bus_fu.resp_y, yu[v]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    bus0.resp_ready = 1'b0;
    bus0.req_valid  = 4'b0011;
    @(negedge clk);
    bus0.req_valid = 4'b0010;
    @(negedge clk);
    bus0.req_valid = '0;
    #1;
    tests_run++;
    if ({bus0.resp_valid, busy0} !== 2'b11) begin
      tests_failed++;
      $display("FAIL ar_fill: got valid=%b busy=%b exp 1 1", bus0.resp_valid, busy0);
    end
    #1;
    rst_n = 1'b0;
    bus0.req_valid = 4'hF;
    #1;
    tests_run++;
    if ({bus0.resp_valid, busy0, bus0.req_ready} !== 6'b0) begin
      tests_failed++;
      $display("FAIL ar_immediate: got valid=%b busy=%b rdy=%b exp 0 0 0000",
               bus0.resp_valid, busy0, bus0.req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus0.req_valid  = '0;
    bus0.resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      tests_run++;
      if ({bus0.resp_valid, busy0} !== 2'b00) begin
        tests_failed++;
        $display("FAIL ar_stale[%0d]: got valid=%b busy=%b exp 0 0", k, bus0.resp_valid, busy0);
      end
      @(negedge clk);
    end
    bus0.req_valid = 4'hF;
    #1;
    tests_run++;
    if (bus0.req_ready !== 4'b0001) begin
      tests_failed++;
      $display("FAIL ar_rr_cleared: got %b exp 0001", bus0.req_ready);
    end
    @(negedge clk);
    bus0.req_valid = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_perf();
`ifdef MUL_ARBITER_PERF_EN
    do_reset();
    #1;
    tests_run++;
    if ({stall0, grants0} !== 32'h0) begin
      tests_failed++;
      $display("FAIL perf_reset: got stall=%0d grants=%0d exp 0 0", stall0, grants0);
    end
    set_op(3, 16'h0001, 16'h0001);
    bus0.resp_ready = 1'b0;
    bus0.req_valid  = 4'b1000;
    @(negedge clk);
    bus0.req_valid = '0;
    @(negedge clk);
    repeat (10) @(negedge clk);
    #1;
    tests_run++;
    if ({stall0, grants0} !== {16'd10, 16'd1}) begin
      tests_failed++;
      $display("FAIL perf_stall: got stall=%0d grants=%0d exp 10 1", stall0, grants0);
    end
    bus0.resp_ready = 1'b1;
    bus0.req_valid  = 4'b1000;
    repeat (2) @(negedge clk);
    bus0.req_valid = '0;
    #1;
    tests_run++;
    if ({stall0, grants0} !== {16'd10, 16'd3}) begin
      tests_failed++;
      $display("FAIL perf_grants: got stall=%0d grants=%0d exp 10 3", stall0, grants0);
    end
    repeat (3) @(negedge clk);
`endif
  endtask

  initial begin
    tests_run         = 0;
    tests_failed      = 0;
    rst_n             = 1'b0;
    bus0.req_valid    = 4'hF;
    bus0.req_a        = '0;
    bus0.req_b        = '0;
    bus0.resp_ready   = 1'b0;
    bus_fs.req_valid  = '0;
    bus_fs.req_a      = '0;
    bus_fs.req_b      = '0;
    bus_fs.resp_ready = 1'b0;
    bus_fu.req_valid  = '0;
    bus_fu.req_a      = '0;
    bus_fu.req_b      = '0;
    bus_fu.resp_ready = 1'b0;
    test_reset();
    test_latency();
    test_round_robin();
    test_single();
    test_back_to_back_backpressure();
    test_full_signed();
    test_async_reset();
    test_perf();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
